xg_link_ctrl: RTL and testbench
===============================

# xg_link_ctrl

Bring-up and recovery sequencer for the 10GBASE-R PCS/PMA link. It sits between the board reset logic, the xg_pcs_pma core and fpga_core, all in the 156.25 MHz coreclk domain. It drives the PCS/PMA reset, waits for transceiver reset-done, QPLL lock and RX block lock with timeouts and retries, and holds fpga_core in reset until the link has been stable for a set time. On loss of lock, SFP module removal or TX fault it tears the link down and re-sequences.

## Interface
- RESET_HOLD, 16: cycles `pcs_reset` is held high per reset attempt (≥1)
- LOCK_TIMEOUT, 1562500: cycles allowed in WAIT_DONE or WAIT_LOCK before a retry (10 ms at 156.25 MHz)
- STABLE_CNT, 1024: consecutive `block_lock` cycles required before link-up (≥1)

- clk  in  1  coreclk, 156.25 MHz
- rst_n  in  1  asynchronous, active-low reset
- link_en  in  1  enables bring-up; low forces IDLE
- resetdone  in  1  PCS/PMA reset done (clk domain)
- qplllock  in  1  QPLL lock (asynchronous, 2-FF synchronised internally)
- block_lock  in  1  RX block lock, status_vector[256] (clk domain)
- mod_abs  in  1  SFP module absent pin (asynchronous, 2-FF synchronised)
- tx_fault  in  1  SFP TX fault pin (asynchronous, 2-FF synchronised)
- pcs_reset  out  1  active-high reset to xg_pcs_pma
- core_rst  out  1  active-high reset to fpga_core
- link_up  out  1  link usable
- retry_cnt  out  8  reset attempts caused by timeout or lock loss, saturating
- state  out  3  current state encoding, for debug

## Operation
- States and encodings: IDLE=0, RESET=1, WAIT_DONE=2, WAIT_LOCK=3, STABLE=4, UP=5, FAULT=6.
- Output decode:
  - `pcs_reset`=1 in IDLE, RESET and FAULT.
  - `core_rst`=0 and `link_up`=1 only in UP.
- Global priority, evaluated every cycle:
  1. From any state other than IDLE: `!link_en` or `mod_abs_s` → IDLE.
  2. Otherwise, from any state other than IDLE or FAULT: `tx_fault_s` → FAULT.
  3. Otherwise, the per-state rules below apply.
- Per-state rules:
  - IDLE: `link_en && !mod_abs_s` → RESET. `retry_cnt` is cleared while `link_en`=0.
  - RESET: the timer counts RESET_HOLD cycles, then → WAIT_DONE with the timer cleared.
  - WAIT_DONE: `resetdone && qplllock_s` → WAIT_LOCK with the timer cleared. On timeout → RESET and `retry_cnt`++.
  - WAIT_LOCK: `block_lock` → STABLE with the counter cleared. On timeout → RESET and `retry_cnt`++. Loss of `resetdone` or `qplllock_s` → RESET and `retry_cnt`++.
  - STABLE: the counter increments on each cycle with `block_lock`=1. When `block_lock`=1 and counter=STABLE_CNT-1 → UP. `block_lock`=0 → WAIT_LOCK with the timer cleared. Loss of `resetdone` or `qplllock_s` → RESET and `retry_cnt`++.
  - UP: `block_lock`=0 → WAIT_LOCK with the timer cleared. Loss of `resetdone` or `qplllock_s` → RESET and `retry_cnt`++ (this takes priority over the `block_lock` rule).
  - FAULT: `!tx_fault_s` → RESET. No retry increment.
- Every entry into RESET reloads the timer so the full RESET_HOLD applies.
- A single shared timer/counter is used. Width is clog2 of max(LOCK_TIMEOUT, RESET_HOLD, STABLE_CNT)+1.
- Timeout fires when the timer equals LOCK_TIMEOUT-1 in WAIT_DONE or WAIT_LOCK.
- `retry_cnt` saturates at 255 and does not wrap.

## Timing
- Reset values: state=IDLE, `pcs_reset`=1, `core_rst`=1, `link_up`=0, `retry_cnt`=0, synchroniser flops at their inactive level (`mod_abs_s`=1, `tx_fault_s`=0, `qplllock_s`=0).
- All outputs are registered and change on the same edge as the state register. There is no combinational path from input to output.
- Pin inputs (`mod_abs`, `tx_fault`, `qplllock`) have 2 cycles of synchroniser latency before they affect state.
- From entering RESET, `pcs_reset` stays high for exactly RESET_HOLD cycles.
- If `block_lock` is first sampled high at edge N in WAIT_LOCK:
  - state=STABLE from N;
  - `link_up`=1 and `core_rst`=0 from edge N+STABLE_CNT, provided lock is held.
- Lock loss while UP: `link_up`=0 and `core_rst`=1 on the next edge.
- Simultaneous events are resolved by the global priority list above.
- Asserting `rst_n` low mid-sequence forces reset values immediately (asynchronous). Release is synchronous to `clk`.

## Test plan
All cases use RESET_HOLD=4, LOCK_TIMEOUT=100, STABLE_CNT=8.
- Clean bring-up: release `rst_n`, set `link_en`=1, `mod_abs`=0, raise `resetdone`/`qplllock` 10 cycles later and `block_lock` 20 cycles after that → `pcs_reset` high for exactly 4 cycles; `link_up` rises exactly 8 cycles after the STABLE entry; `retry_cnt`=0.
- Timeout retry: `block_lock` never asserts → every 100 cycles in WAIT_LOCK, state→RESET, `pcs_reset` pulses 4 cycles and `retry_cnt` increments; after 300 increments `retry_cnt` reads 255.
- Lock glitch: in STABLE, drop `block_lock` for 1 cycle at count 5 → returns to WAIT_LOCK; `link_up` is only asserted after 8 further contiguous lock cycles.
- Link loss while UP: drop `block_lock` → `link_up`=0 and `core_rst`=1 on the next edge, state=WAIT_LOCK, `retry_cnt` unchanged. Drop `qplllock` instead → state=RESET 3 cycles later, `retry_cnt`+1.
- Module and fault events: raise `mod_abs` while UP → IDLE 3 cycles later with `pcs_reset`=1. Raise `tx_fault` together with `mod_abs` → IDLE wins. Raise `tx_fault` alone → FAULT; on release → RESET.
- Async reset mid-STABLE: pulse `rst_n` low for half a clock → all outputs take reset values immediately; sequencing restarts from IDLE.

Source files
------------

// File: rtl/xg_link_ctrl_if.sv
// Signal bundle between the 10GBASE-R link sequencer and the board/PCS side.
// The master side is the sequencer; the slave side is board pins, xg_pcs_pma status and fpga_core.
interface xg_link_ctrl_if;
  logic       link_en;
  logic       resetdone;
  logic       qplllock;
  logic       block_lock;
  logic       mod_abs;
  logic       tx_fault;
  logic       pcs_reset;
  logic       core_rst;
  logic       link_up;
  logic [7:0] retry_cnt;
  logic [2:0] state;

  modport master (
    input  link_en, resetdone, qplllock, block_lock, mod_abs, tx_fault,
    output pcs_reset, core_rst, link_up, retry_cnt, state
  );

  modport slave (
    output link_en, resetdone, qplllock, block_lock, mod_abs, tx_fault,
    input  pcs_reset, core_rst, link_up, retry_cnt, state
  );
endinterface

// File: rtl/xg_link_ctrl.sv
// Bring-up and recovery sequencer for the 10GBASE-R PCS/PMA link in the coreclk domain.
// Drives the PCS/PMA reset, waits for reset-done, QPLL and block lock, and gates fpga_core reset.
module xg_link_ctrl #(
  parameter int unsigned RESET_HOLD   = 16,
  parameter int unsigned LOCK_TIMEOUT = 1562500,
  parameter int unsigned STABLE_CNT   = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  xg_link_ctrl_if.master link
);

  localparam int unsigned MAX_A = (LOCK_TIMEOUT > RESET_HOLD) ? LOCK_TIMEOUT : RESET_HOLD;
  localparam int unsigned MAX_V = (MAX_A > STABLE_CNT) ? MAX_A : STABLE_CNT;
  localparam int unsigned TW    = $clog2(MAX_V + 1);

  localparam logic [TW-1:0] HOLD_LAST    = TW'(RESET_HOLD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_STABLE    = 3'd4,
    ST_UP        = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  logic [1:0]    mod_abs_sync_r;
  logic [1:0]    tx_fault_sync_r;
  logic [1:0]    qpll_sync_r;
  logic          mod_abs_s;
  logic          tx_fault_s;
  logic          qplllock_s;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [TW-1:0] timer_r;
  logic [7:0]    retry_r;
  logic          retry_inc_s;
  logic          lost_s;
  logic          timeout_s;
  logic          pcs_reset_r;
  logic          core_rst_r;
  logic          link_up_r;

  // Two-flop synchronisers for the asynchronous pins, reset to their inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_abs_sync_r  <= 2'b11;
      tx_fault_sync_r <= 2'b00;
      qpll_sync_r     <= 2'b00;
    end else begin
      mod_abs_sync_r  <= {mod_abs_sync_r[0], link.mod_abs};
      tx_fault_sync_r <= {tx_fault_sync_r[0], link.tx_fault};
      qpll_sync_r     <= {qpll_sync_r[0], link.qplllock};
    end
  end

  assign mod_abs_s  = mod_abs_sync_r[1];
  assign tx_fault_s = tx_fault_sync_r[1];
  assign qplllock_s = qpll_sync_r[1];

  assign lost_s    = !link.resetdone || !qplllock_s;
  assign timeout_s = (timer_r == TIMEOUT_LAST);

  // Next-state selection: teardown conditions first, then the per-state rules.
  always_comb begin
    state_nxt_s = state_r;
    retry_inc_s = 1'b0;
    if ((state_r != ST_IDLE) && (!link.link_en || mod_abs_s)) begin
      state_nxt_s = ST_IDLE;
    end else if ((state_r != ST_IDLE) && (state_r != ST_FAULT) && tx_fault_s) begin
      state_nxt_s = ST_FAULT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (link.link_en && !mod_abs_s) begin
            state_nxt_s = ST_RESET;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RESET: begin
          if (timer_r == HOLD_LAST) begin
            state_nxt_s = ST_WAIT_DONE;
          end else begin
            state_nxt_s = ST_RESET;
          end
        end
        ST_WAIT_DONE: begin
          if (link.resetdone && qplllock_s) begin
            state_nxt_s = ST_WAIT_LOCK;
          end else if (timeout_s) begin
            state_nxt_s = ST_RESET;
            retry_inc_s = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT_DONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (lost_s || (!link.block_lock && timeout_s)) begin
            state_nxt_s = ST_RESET;
            retry_inc_s = 1'b1;
          end else if (link.block_lock) begin
            state_nxt_s = ST_STABLE;
          end else begin
            state_nxt_s = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          if (lost_s) begin
            state_nxt_s = ST_RESET;
            retry_inc_s = 1'b1;
          end else if (!link.block_lock) begin
            state_nxt_s = ST_WAIT_LOCK;
          end else if (timer_r == STABLE_LAST) begin
            state_nxt_s = ST_UP;
          end else begin
            state_nxt_s = ST_STABLE;
          end
        end
        ST_UP: begin
          if (lost_s) begin
            state_nxt_s = ST_RESET;
            retry_inc_s = 1'b1;
          end else if (!link.block_lock) begin
            state_nxt_s = ST_WAIT_LOCK;
          end else begin
            state_nxt_s = ST_UP;
          end
        end
        ST_FAULT: begin
          if (!tx_fault_s) begin
            state_nxt_s = ST_RESET;
          end else begin
            state_nxt_s = ST_FAULT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, shared timer, retry counter and outputs decoded from the next state so they move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      timer_r     <= '0;
      retry_r     <= 8'd0;
      pcs_reset_r <= 1'b1;
      core_rst_r  <= 1'b1;
      link_up_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      // Any state change clears the timer; states with no timed rule keep it parked at zero.
      if ((state_nxt_s != state_r) || (state_nxt_s inside {ST_IDLE, ST_UP, ST_FAULT})) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TW'(1);
      end
      if ((state_r == ST_IDLE) && !link.link_en) begin
        retry_r <= 8'd0;
      end else if (retry_inc_s && (retry_r != 8'd255)) begin
        retry_r <= retry_r + 8'd1;
      end else begin
        retry_r <= retry_r;
      end
      pcs_reset_r <= (state_nxt_s inside {ST_IDLE, ST_RESET, ST_FAULT});
      core_rst_r  <= (state_nxt_s != ST_UP);
      link_up_r   <= (state_nxt_s == ST_UP);
    end
  end

  assign link.pcs_reset = pcs_reset_r;
  assign link.core_rst  = core_rst_r;
  assign link.link_up   = link_up_r;
  assign link.retry_cnt = retry_r;
  assign link.state     = state_r;

endmodule

// File: tb/tb_xg_link_ctrl.sv
// Directed bench for xg_link_ctrl with RESET_HOLD=4, LOCK_TIMEOUT=100, STABLE_CNT=8.
module tb_xg_link_ctrl;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  xg_link_ctrl_if lif ();

  xg_link_ctrl #(
    .RESET_HOLD  (4),
    .LOCK_TIMEOUT(100),
    .STABLE_CNT  (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .link (lif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (lif.state == st) break;
    end
    check(tag, {29'd0, lif.state}, {29'd0, st});
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    lif.link_en    = 1'b0;
    lif.mod_abs    = 1'b1;
    lif.tx_fault   = 1'b0;
    lif.qplllock   = 1'b0;
    lif.resetdone  = 1'b0;
    lif.block_lock = 1'b0;
    step(3);
    check("rst_state",     lif.state,     32'd0);
    check("rst_pcs_reset", lif.pcs_reset, 32'd1);
    check("rst_core_rst",  lif.core_rst,  32'd1);
    check("rst_link_up",   lif.link_up,   32'd0);
    check("rst_retry",     lif.retry_cnt, 32'd0);

    // Clean bring-up
    rst_n = 1'b1; lif.link_en = 1'b1; lif.mod_abs = 1'b0;
    step(2);  check("sync_lat_idle",   lif.state, 32'd0);
    step(1);  check("enter_reset",     lif.state, 32'd1);
              check("pcs_reset_start", lif.pcs_reset, 32'd1);
    step(3);  check("reset_4th_cycle", lif.state, 32'd1);
              check("pcs_reset_4th",   lif.pcs_reset, 32'd1);
    step(1);  check("wait_done_entry", lif.state, 32'd2);
              check("pcs_reset_low",   lif.pcs_reset, 32'd0);
              check("core_rst_held",   lif.core_rst, 32'd1);
    step(3);  lif.resetdone = 1'b1; lif.qplllock = 1'b1;
    step(2);  check("qpll_sync_wait",  lif.state, 32'd2);
    step(1);  check("wait_lock_entry", lif.state, 32'd3);
    step(5);  check("wait_lock_hold",  lif.state, 32'd3);
    lif.block_lock = 1'b1;
    step(1);  check("stable_entry",    lif.state, 32'd4);
    step(7);  check("stable_n7_state", lif.state, 32'd4);
              check("stable_n7_down",  lif.link_up, 32'd0);
    step(1);  check("up_state",        lif.state, 32'd5);
              check("up_link_up",      lif.link_up, 32'd1);
              check("up_core_rst",     lif.core_rst, 32'd0);
              check("up_retry",        lif.retry_cnt, 32'd0);

    // Block lock loss while UP
    step(1);  lif.block_lock = 1'b0;
    step(1);  check("loss_state",      lif.state, 32'd3);
              check("loss_link_up",    lif.link_up, 32'd0);
              check("loss_core_rst",   lif.core_rst, 32'd1);
              check("loss_retry",      lif.retry_cnt, 32'd0);

    // Lock glitch at stable count 5
    lif.block_lock = 1'b1;
    step(1);  check("relock_stable",   lif.state, 32'd4);
    step(5);  check("stable_cnt5",     lif.state, 32'd4);
    lif.block_lock = 1'b0;
    step(1);  check("glitch_waitlock", lif.state, 32'd3);
    lif.block_lock = 1'b1;
    step(1);  check("glitch_stable",   lif.state, 32'd4);
    step(7);  check("glitch_not_up",   lif.link_up, 32'd0);
    step(1);  check("glitch_up",       lif.link_up, 32'd1);
              check("glitch_up_state", lif.state, 32'd5);

    // QPLL loss while UP
    lif.qplllock = 1'b0;
    step(2);  check("qpll_loss_lat",   lif.state, 32'd5);
    step(1);  check("qpll_loss_reset", lif.state, 32'd1);
              check("qpll_loss_retry", lif.retry_cnt, 32'd1);
              check("qpll_loss_pcs",   lif.pcs_reset, 32'd1);
              check("qpll_loss_lnk",   lif.link_up, 32'd0);
    lif.qplllock = 1'b1;
    wait_state(3'd5, 100, "reup_after_qpll");

    // Module removal while UP
    lif.mod_abs = 1'b1;
    step(2);  check("modabs_lat",      lif.state, 32'd5);
    step(1);  check("modabs_idle",     lif.state, 32'd0);
              check("modabs_pcs",      lif.pcs_reset, 32'd1);
              check("modabs_core",     lif.core_rst, 32'd1);
              check("modabs_link",     lif.link_up, 32'd0);
    lif.mod_abs = 1'b0;
    wait_state(3'd5, 100, "reup_after_modabs");
    check("modabs_keeps_retry", lif.retry_cnt, 32'd1);

    // tx_fault together with mod_abs: IDLE wins
    lif.mod_abs = 1'b1; lif.tx_fault = 1'b1;
    step(3);  check("idle_beats_fault", lif.state, 32'd0);
    lif.mod_abs = 1'b0; lif.tx_fault = 1'b0;
    wait_state(3'd5, 100, "reup_after_both");

    // tx_fault alone
    lif.tx_fault = 1'b1;
    step(2);  check("fault_lat",       lif.state, 32'd5);
    step(1);  check("fault_state",     lif.state, 32'd6);
              check("fault_pcs",       lif.pcs_reset, 32'd1);
              check("fault_link",      lif.link_up, 32'd0);
    lif.tx_fault = 1'b0;
    step(2);  check("fault_hold",      lif.state, 32'd6);
    step(1);  check("fault_to_reset",  lif.state, 32'd1);
              check("fault_no_retry",  lif.retry_cnt, 32'd1);

    // Async reset mid-STABLE
    wait_state(3'd4, 100, "reach_stable");
    #1 rst_n = 1'b0;
    #1;
    check("arst_state",     lif.state, 32'd0);
    check("arst_pcs_reset", lif.pcs_reset, 32'd1);
    check("arst_core_rst",  lif.core_rst, 32'd1);
    check("arst_link_up",   lif.link_up, 32'd0);
    check("arst_retry",     lif.retry_cnt, 32'd0);
    #3 rst_n = 1'b1;
    step(2);  check("arst_idle_sync",  lif.state, 32'd0);
    step(1);  check("arst_restart",    lif.state, 32'd1);
    wait_state(3'd5, 100, "reup_after_arst");

    // Timeout retries with block_lock never returning
    lif.block_lock = 1'b0;
    step(1);   check("to_waitlock",     lif.state, 32'd3);
    step(99);  check("to_before",       lif.state, 32'd3);
    step(1);   check("to_reset",        lif.state, 32'd1);
               check("to_retry1",       lif.retry_cnt, 32'd1);
               check("to_pcs",          lif.pcs_reset, 32'd1);
    step(4);   check("to_wait_done",    lif.state, 32'd2);
               check("to_pcs_low",      lif.pcs_reset, 32'd0);
    step(1);   check("to_waitlock2",    lif.state, 32'd3);
    step(100); check("to_reset2",       lif.state, 32'd1);
               check("to_retry2",       lif.retry_cnt, 32'd2);
    step(105 * 252); check("to_retry254", lif.retry_cnt, 32'd254);
    step(105);       check("to_retry255", lif.retry_cnt, 32'd255);
    step(105 * 45);  check("to_retry_sat", lif.retry_cnt, 32'd255);
                     check("to_sat_state", lif.state, 32'd1);

    // link_en low: IDLE, then retry count cleared
    lif.link_en = 1'b0;
    step(1);  check("dis_idle",        lif.state, 32'd0);
              check("dis_retry_kept",  lif.retry_cnt, 32'd255);
    step(1);  check("dis_retry_clr",   lif.retry_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
